// File: rtl/mpram_wr_arbiter_if.sv
// Write-request and RAM write-port bundle between the requesters, mpram_wr_arbiter and multiport_ram.
// Optional conflict_cnt_o is present when MPRAM_WR_ARBITER_STATS_EN is defined.
interface mpram_wr_arbiter_if #(
    parameter int unsigned P_NUM_REQ   = 4,
    parameter int unsigned P_MEM_DEPTH = 2048,
    parameter int unsigned P_MEM_WIDTH = 32
);
    localparam int unsigned LP_INDEX_WIDTH = $clog2(P_MEM_DEPTH);

    logic [P_NUM_REQ-1:0]                req_valid_i;
    logic [P_NUM_REQ*LP_INDEX_WIDTH-1:0] req_addr_i;
    logic [P_NUM_REQ*P_MEM_WIDTH-1:0]    req_data_i;
    logic [P_NUM_REQ-1:0]                req_ready_o;
    logic [LP_INDEX_WIDTH-1:0]           wra_addr_o;
    logic [P_MEM_WIDTH-1:0]              wra_data_o;
    logic                                wra_valid_o;
    logic [LP_INDEX_WIDTH-1:0]           wrb_addr_o;
    logic [P_MEM_WIDTH-1:0]              wrb_data_o;
    logic                                wrb_valid_o;
`ifdef MPRAM_WR_ARBITER_STATS_EN
    logic [15:0]                         conflict_cnt_o;
`endif

    // Requester/RAM side
    modport master (
        output req_valid_i, req_addr_i, req_data_i,
        input  req_ready_o, wra_addr_o, wra_data_o, wra_valid_o,
        input  wrb_addr_o, wrb_data_o, wrb_valid_o
`ifdef MPRAM_WR_ARBITER_STATS_EN
        , input conflict_cnt_o
`endif
    );

    // Arbiter side
    modport slave (
        input  req_valid_i, req_addr_i, req_data_i,
        output req_ready_o, wra_addr_o, wra_data_o, wra_valid_o,
        output wrb_addr_o, wrb_data_o, wrb_valid_o
`ifdef MPRAM_WR_ARBITER_STATS_EN
        , output conflict_cnt_o
`endif
    );
endinterface

// File: rtl/mpram_wr_arbiter.sv
// Round-robin arbiter sharing the two RAM write ports among P_NUM_REQ requesters.
// Define MPRAM_WR_ARBITER_STATS_EN to add the saturating conflict_cnt_o counter.
module mpram_wr_arbiter #(
    parameter int unsigned P_NUM_REQ   = 4,
    parameter int unsigned P_MEM_DEPTH = 2048,
    parameter int unsigned P_MEM_WIDTH = 32
) (
    input logic               clk_i,
    input logic               rst_ni,
    mpram_wr_arbiter_if.slave bus
);
    localparam int unsigned LP_INDEX_WIDTH = $clog2(P_MEM_DEPTH);
    localparam int unsigned LP_PTR_WIDTH   = $clog2(P_NUM_REQ);
    localparam int unsigned LP_SUM_WIDTH   = LP_PTR_WIDTH + 1;

    logic [LP_PTR_WIDTH-1:0]   ptr;
    logic [LP_PTR_WIDTH-1:0]   ptr_next;
    logic [LP_PTR_WIDTH-1:0]   idx_a;
    logic [LP_PTR_WIDTH-1:0]   idx_b;
    logic [LP_PTR_WIDTH-1:0]   idx;
    logic [LP_SUM_WIDTH-1:0]   scan;
    logic                      grant_a;
    logic                      grant_b;
    logic [LP_INDEX_WIDTH-1:0] addr_a;
    logic [P_NUM_REQ-1:0]      ready;
`ifdef MPRAM_WR_ARBITER_STATS_EN
    logic                      conflict;
    logic [15:0]               conflict_cnt;
`endif

    logic [LP_INDEX_WIDTH-1:0] addr_arr [P_NUM_REQ];
    logic [P_MEM_WIDTH-1:0]    data_arr [P_NUM_REQ];

    for (genvar g = 0; g < P_NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = bus.req_addr_i[g*LP_INDEX_WIDTH +: LP_INDEX_WIDTH];
        assign data_arr[g] = bus.req_data_i[g*P_MEM_WIDTH +: P_MEM_WIDTH];
    end

    function automatic logic [LP_PTR_WIDTH-1:0] inc_mod(input logic [LP_PTR_WIDTH-1:0] v);
        logic [LP_SUM_WIDTH-1:0] s;
        s = LP_SUM_WIDTH'(v) + LP_SUM_WIDTH'(1);
        if (s >= LP_SUM_WIDTH'(P_NUM_REQ)) s = '0;
        return LP_PTR_WIDTH'(s);
    endfunction

    // Scan from ptr: first valid wins A, next valid with a different address wins B
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        idx_a   = '0;
        idx_b   = '0;
        addr_a  = '0;
        scan    = '0;
        idx     = '0;
`ifdef MPRAM_WR_ARBITER_STATS_EN
        conflict = 1'b0;
`endif
        for (int unsigned k = 0; k < P_NUM_REQ; k++) begin
            scan = LP_SUM_WIDTH'(ptr) + LP_SUM_WIDTH'(k);
            if (scan >= LP_SUM_WIDTH'(P_NUM_REQ)) scan = scan - LP_SUM_WIDTH'(P_NUM_REQ);
            idx = LP_PTR_WIDTH'(scan);
            if (bus.req_valid_i[idx]) begin
                if (!grant_a) begin
                    grant_a = 1'b1;
                    idx_a   = idx;
                    addr_a  = addr_arr[idx];
                end else if (addr_arr[idx] == addr_a) begin
`ifdef MPRAM_WR_ARBITER_STATS_EN
                    conflict = 1'b1;
`endif
                end else if (!grant_b) begin
                    grant_b = 1'b1;
                    idx_b   = idx;
                end
            end
        end
    end

    // Ready is a pure function of the requests and ptr, held low during reset
    always_comb begin
        ready = '0;
        if (rst_ni) begin
            if (grant_a) ready[idx_a] = 1'b1;
            if (grant_b) ready[idx_b] = 1'b1;
        end
    end
    assign bus.req_ready_o = ready;

    always_comb begin
        ptr_next = ptr;
        if (grant_b)      ptr_next = inc_mod(idx_b);
        else if (grant_a) ptr_next = inc_mod(idx_a);
    end

    // Registered issue to the RAM write ports; idle ports keep their last addr/data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr             <= '0;
            bus.wra_addr_o  <= '0;
            bus.wra_data_o  <= '0;
            bus.wra_valid_o <= 1'b0;
            bus.wrb_addr_o  <= '0;
            bus.wrb_data_o  <= '0;
            bus.wrb_valid_o <= 1'b0;
        end else begin
            ptr             <= ptr_next;
            bus.wra_valid_o <= grant_a;
            bus.wrb_valid_o <= grant_b;
            if (grant_a) begin
                bus.wra_addr_o <= addr_a;
                bus.wra_data_o <= data_arr[idx_a];
            end
            if (grant_b) begin
                bus.wrb_addr_o <= addr_arr[idx_b];
                bus.wrb_data_o <= data_arr[idx_b];
            end
        end
    end

`ifdef MPRAM_WR_ARBITER_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                   conflict_cnt <= '0;
        else if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end
    assign bus.conflict_cnt_o = conflict_cnt;
`endif
endmodule
